furv: RTL and testbench
=======================

FURV -- requirements
Module: furv

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the address fetched first after reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port instr, input, 32 bits: instruction word at the current pc, supplied combinationally by the environment.
REQ-005 SHALL have port pc, output, 32 bits: current fetch address (byte address).
REQ-006 SHALL have port data, output, 32 bits: store data, the full rs2 value, unmodified.
REQ-007 SHALL have port addr, output, 32 bits: memory byte address, rs1 + sign-extended 12-bit offset.
REQ-008 SHALL have port mem_read, output, 1 bit: 1 = load access, 0 = store access; meaningful only while mem=1.
REQ-009 SHALL have port mem, output, 1 bit: memory access valid this cycle.

Function
REQ-010 SHALL be a single-cycle, non-pipelined RV32I-subset core: one instruction per clk cycle, with decode, execute and memory outputs combinational from instr and architectural state.
REQ-011 SHALL provide 32 registers x0..x31 of 32 bits each; x0 reads 0 and ignores writes; rd is written on the rising clk edge ending the instruction.
REQ-012 SHALL execute OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI; immediates sign-extended; shift amount is imm[4:0].
REQ-013 SHALL execute OP: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND; funct7 bit 30 selects SUB/SRA; shift amount is rs2[4:0].
REQ-014 SHALL execute LUI and AUIPC.
REQ-015 SHALL execute JAL and JALR with rd = pc+4; JALR target clears bit 0.
REQ-016 SHALL execute BEQ, BNE, BLT, BGE, BLTU, BGEU: target = pc + sign-extended B-immediate when taken, else pc+4.
REQ-017 SHALL, for STORE (SB/SH/SW), drive mem=1, mem_read=0, addr=rs1+imm, data=rs2 for that cycle; width is not signalled; there is no register write.
REQ-018 SHALL, for LOAD, drive mem=1, mem_read=1, addr=rs1+imm; there is no read-data port, so rd is written with 0.
REQ-019 SHALL drive mem=0 and mem_read=0 for all non-memory instructions; addr and data are don't-care while mem=0, but are driven to 0.
REQ-020 SHALL treat any unrecognised opcode (including FENCE/SYSTEM) as a NOP: no writes, mem=0, pc advances by 4.
REQ-021 SHALL wrap all arithmetic, including pc and address computation, modulo 2^32; there are no traps and no misalignment checks.
REQ-022 SHALL update pc only on the rising clk edge, to the next-pc computed above.

Reset
REQ-023 SHALL, while rst_n=0 (asynchronously), set pc=RESET_PC and clear all registers to 0.
REQ-024 SHALL, during reset, force mem=0 and mem_read=0; the first instruction executes in the first cycle after rst_n rises.
REQ-025 SHALL, on reset asserted mid-program, discard the instruction in progress: no register write and no memory access.

Structure
REQ-026 SHALL place the opcode, funct3 and ALU-operation constants and the immediate-type enum in the shared package furv_pkg.
REQ-027 SHALL implement the register file as sub-module furv_regfile (2 async read ports, 1 sync write port, async clear); ALU and decode stay inline.

Verification
REQ-028 SHALL cover reset: rst_n=0 -> pc=0, mem=0; release -> pc steps 0,4,8 on NOPs (32'h00000013).
REQ-029 SHALL cover a store loop: program 40000113, 01000193, 00110023, 00108093, fe309ce3 at words 0..4 -> exactly 16 store cycles with addr=1024, data=0..15 in order, then pc=20.
REQ-030 SHALL cover sign extension: addi x1,x0,-1; sw x1,0(x0) -> addr=0, data=32'hFFFFFFFF, mem_read=0.
REQ-031 SHALL cover branches and jumps: bne not taken -> pc+4; jal x5,+16 at pc 8 -> pc=24, and a store of x5 shows data=12.
REQ-032 SHALL cover loads: lw x2,4(x0) -> mem=1, mem_read=1, addr=4; a later store of x2 shows data=0.
REQ-033 SHALL cover writes to x0: addi x0,x0,5 then sw x0 -> data=0.

Source files
------------

// File: rtl/furv_pkg.sv
// rtl/furv_pkg.sv - opcode, funct3, ALU-operation and immediate-type definitions shared by furv
package furv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    function automatic logic [31:0] imm_gen(input logic [31:0] ins, input imm_type_e kind);
        logic [31:0] imm;
        case (kind)
            IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm = {ins[31:12], 12'b0};
            IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = {{20{ins[31]}}, ins[31:20]};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/furv_regfile.sv
// rtl/furv_regfile.sv - 32x32 register file, two async read ports, one sync write port, async clear
module furv_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    // x0 is never written, so it stays at its reset value of zero
    always_comb begin
        regs_d = regs_q;
        if (we && (wa != 5'd0)) begin
            regs_d[wa] = wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs_q[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs_q[ra2];

endmodule

// File: rtl/furv.sv
// rtl/furv.sv - single-cycle RV32I-subset core; decode, ALU and memory outputs are combinational
module furv
    import furv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] data,
    output logic [31:0] addr,
    output logic        mem_read,
    output logic        mem
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;

    logic [6:0]  opcode;
    logic [4:0]  rd_idx, rs1_idx, rs2_idx;
    logic [2:0]  funct3;
    logic        alt;

    logic [31:0] rs1_val, rs2_val;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    logic [3:0]  alu_op;
    logic [31:0] alu_b, alu_y;
    logic        taken;

    logic        rf_we;
    logic [31:0] rf_wd;
    logic        mem_op, load_op;
    logic [31:0] mem_off;

    assign opcode  = instr[6:0];
    assign rd_idx  = instr[11:7];
    assign funct3  = instr[14:12];
    assign rs1_idx = instr[19:15];
    assign rs2_idx = instr[24:20];
    assign alt     = instr[30];

    assign imm_i = imm_gen(instr, IMM_I);
    assign imm_s = imm_gen(instr, IMM_S);
    assign imm_b = imm_gen(instr, IMM_B);
    assign imm_u = imm_gen(instr, IMM_U);
    assign imm_j = imm_gen(instr, IMM_J);

    furv_regfile u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (rs1_idx),
        .ra2   (rs2_idx),
        .rd1   (rs1_val),
        .rd2   (rs2_val),
        .we    (rf_we),
        .wa    (rd_idx),
        .wd    (rf_wd)
    );

    // bit 30 means SUB only for register-register ops; for ADDI it is an immediate bit
    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            F3_ADD:  alu_op = ((opcode == OPC_OP) && alt) ? ALU_SUB : ALU_ADD;
            F3_SLL:  alu_op = ALU_SLL;
            F3_SLT:  alu_op = ALU_SLT;
            F3_SLTU: alu_op = ALU_SLTU;
            F3_XOR:  alu_op = ALU_XOR;
            F3_SR:   alu_op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   alu_op = ALU_OR;
            F3_AND:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

    assign alu_b = (opcode == OPC_OP) ? rs2_val : imm_i;

    always_comb begin
        alu_y = '0;
        case (alu_op)
            ALU_ADD:  alu_y = rs1_val + alu_b;
            ALU_SUB:  alu_y = rs1_val - alu_b;
            ALU_SLL:  alu_y = rs1_val << alu_b[4:0];
            ALU_SLT:  alu_y = {31'b0, $signed(rs1_val) < $signed(alu_b)};
            ALU_SLTU: alu_y = {31'b0, rs1_val < alu_b};
            ALU_XOR:  alu_y = rs1_val ^ alu_b;
            ALU_SRL:  alu_y = rs1_val >> alu_b[4:0];
            ALU_SRA:  alu_y = $unsigned($signed(rs1_val) >>> alu_b[4:0]);
            ALU_OR:   alu_y = rs1_val | alu_b;
            ALU_AND:  alu_y = rs1_val & alu_b;
            default:  alu_y = '0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1_val == rs2_val);
            F3_BNE:  taken = (rs1_val != rs2_val);
            F3_BLT:  taken = ($signed(rs1_val) < $signed(rs2_val));
            F3_BGE:  taken = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: taken = (rs1_val < rs2_val);
            F3_BGEU: taken = (rs1_val >= rs2_val);
            default: taken = 1'b0;
        endcase
    end

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d    = pc_plus4;
        rf_we   = 1'b0;
        rf_wd   = '0;
        mem_op  = 1'b0;
        load_op = 1'b0;
        mem_off = imm_i;
        case (opcode)
            OPC_OPIMM, OPC_OP: begin
                rf_we = 1'b1;
                rf_wd = alu_y;
            end
            OPC_LUI: begin
                rf_we = 1'b1;
                rf_wd = imm_u;
            end
            OPC_AUIPC: begin
                rf_we = 1'b1;
                rf_wd = pc_q + imm_u;
            end
            OPC_JAL: begin
                rf_we = 1'b1;
                rf_wd = pc_plus4;
                pc_d  = pc_q + imm_j;
            end
            OPC_JALR: begin
                rf_we = 1'b1;
                rf_wd = pc_plus4;
                pc_d  = (rs1_val + imm_i) & ~32'd1;
            end
            OPC_BRANCH: begin
                if (taken) begin
                    pc_d = pc_q + imm_b;
                end
            end
            // no read-data path exists, so a load retires with rd = 0
            OPC_LOAD: begin
                mem_op  = 1'b1;
                load_op = 1'b1;
                rf_we   = 1'b1;
                rf_wd   = '0;
            end
            OPC_STORE: begin
                mem_op  = 1'b1;
                mem_off = imm_s;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc       = pc_q;
    assign mem      = mem_op & rst_n;
    assign mem_read = load_op & rst_n;
    assign addr     = mem ? (rs1_val + mem_off) : 32'd0;
    assign data     = (mem && !load_op) ? rs2_val : 32'd0;

endmodule

// File: tb/tb_furv.sv
// tb/tb_furv.sv - instruction-level reference model with directed programs and random programs
module tb_furv;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr, pc, data, addr;
    logic        mem_read, mem;

    furv #(.RESET_PC(32'h0000_0000)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .instr    (instr),
        .pc       (pc),
        .data     (data),
        .addr     (addr),
        .mem_read (mem_read),
        .mem      (mem)
    );

    always #5 clk = ~clk;

    logic [31:0] imem [64];
    assign instr = imem[pc[7:2]];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] pc;
        logic        ld;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;
    acc_t acc_log[$];

    // architectural state of the reference machine
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic        p_valid = 1'b0;
    logic [31:0] p_pc, p_val;
    logic        p_we;
    logic [4:0]  p_rd;

    function automatic logic [31:0] alu_model(input logic [2:0] f3, input logic alt,
                                              input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (f3)
            3'd0:    return alt ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return (sa < sb) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return alt ? 32'(sa >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic model_eval(input logic [31:0] ins, output logic e_mem, output logic e_rd,
                              output logic [31:0] e_addr, output logic [31:0] e_data,
                              output logic [31:0] n_pc, output logic w_en, output logic [31:0] w_val);
        logic [31:0] a, b, ii, is, ib, iu, ij;
        int sa, sb;
        logic [2:0] f3;
        logic tk;
        a  = m_regs[ins[19:15]];
        b  = m_regs[ins[24:20]];
        sa = a;
        sb = b;
        f3 = ins[14:12];
        ii = {{20{ins[31]}}, ins[31:20]};
        is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        iu = {ins[31:12], 12'b0};
        ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        n_pc = m_pc + 32'd4;
        w_en = 1'b0; w_val = '0;
        e_mem = 1'b0; e_rd = 1'b0; e_addr = '0; e_data = '0;
        case (ins[6:0])
            7'h13: begin w_en = 1'b1; w_val = alu_model(f3, ins[30] && f3 == 3'd5, a, ii); end
            7'h33: begin w_en = 1'b1; w_val = alu_model(f3, ins[30], a, b); end
            7'h37: begin w_en = 1'b1; w_val = iu; end
            7'h17: begin w_en = 1'b1; w_val = m_pc + iu; end
            7'h6f: begin w_en = 1'b1; w_val = m_pc + 32'd4; n_pc = m_pc + ij; end
            7'h67: begin w_en = 1'b1; w_val = m_pc + 32'd4; n_pc = (a + ii) & 32'hFFFF_FFFE; end
            7'h63: begin
                case (f3)
                    3'd0:    tk = (a == b);
                    3'd1:    tk = (a != b);
                    3'd4:    tk = (sa < sb);
                    3'd5:    tk = (sa >= sb);
                    3'd6:    tk = (a < b);
                    3'd7:    tk = (a >= b);
                    default: tk = 1'b0;
                endcase
                if (tk) n_pc = m_pc + ib;
            end
            7'h03: begin e_mem = 1'b1; e_rd = 1'b1; e_addr = a + ii; w_en = 1'b1; w_val = '0; end
            7'h23: begin e_mem = 1'b1; e_addr = a + is; e_data = b; end
            default: ;
        endcase
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 32'd0;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            p_valid = 1'b0;
        end else if (p_valid) begin
            m_pc = p_pc;
            if (p_we && p_rd != 5'd0) m_regs[p_rd] = p_val;
            p_valid = 1'b0;
        end
    end

    always @(negedge clk) begin : cmp
        logic e_mem, e_rd, w_en;
        logic [31:0] e_addr, e_data, n_pc, w_val, ins;
        acc_t ent;
        ins = imem[m_pc[7:2]];
        model_eval(ins, e_mem, e_rd, e_addr, e_data, n_pc, w_en, w_val);
        if (!rst_n) begin
            chk("rst_pc", pc, 32'd0);
            chk("rst_mem", 32'(mem), 32'd0);
            chk("rst_mem_read", 32'(mem_read), 32'd0);
        end else begin
            chk("pc", pc, m_pc);
            chk("mem", 32'(mem), 32'(e_mem));
            chk("mem_read", 32'(mem_read), 32'(e_rd));
            if (e_mem) chk("addr", addr, e_addr);
            if (e_mem && !e_rd) chk("data", data, e_data);
            if (!e_mem) begin
                chk("idle_addr", addr, 32'd0);
                chk("idle_data", data, 32'd0);
            end
            if (mem) begin
                ent.pc = pc; ent.ld = mem_read; ent.addr = addr; ent.data = data;
                acc_log.push_back(ent);
            end
        end
        p_pc = n_pc; p_we = w_en; p_rd = ins[11:7]; p_val = w_val; p_valid = 1'b1;
    end

    task automatic restart(input logic [31:0] p[$]);
        @(negedge clk);
        #1 rst_n = 1'b0;
        for (int i = 0; i < 64; i++) imem[i] = NOP;
        foreach (p[i]) imem[i] = p[i];
        #1;
        chk("async_rst_pc", pc, 32'd0);
        chk("async_rst_mem", 32'(mem), 32'd0);
        acc_log.delete();
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 15);
        w[11:10] = 2'b00;
        w[19:18] = 2'b00;
        w[24:23] = 2'b00;
        case (k)
            0, 1, 2, 3: w[6:0] = 7'h13;
            4, 5, 6:    begin w[6:0] = 7'h33; w[31] = 1'b0; w[29:25] = 5'd0; end
            7:          w[6:0] = 7'h37;
            8:          w[6:0] = 7'h17;
            9:          w[6:0] = 7'h6f;
            10:         w[6:0] = 7'h67;
            11, 12:     w[6:0] = 7'h63;
            13:         w[6:0] = 7'h03;
            14:         w[6:0] = 7'h23;
            default:    w[6:0] = ($urandom_range(0, 1) == 0) ? 7'h73 : w[6:0];
        endcase
        return w;
    endfunction

    initial begin
        logic [31:0] prog[$];
        for (int i = 0; i < 64; i++) imem[i] = NOP;

        // reset and NOP stepping
        prog = '{NOP};
        restart(prog);
        chk("t1_pc0", pc, 32'd0);
        @(posedge clk); #1 chk("t1_pc4", pc, 32'd4);
        chk("t1_mem", 32'(mem), 32'd0);
        @(posedge clk); #1 chk("t1_pc8", pc, 32'd8);

        // counted store loop
        prog = '{32'h40000113, 32'h01000193, 32'h00110023, 32'h00108093, 32'hfe309ce3};
        restart(prog);
        for (int c = 0; c < 200 && pc != 32'd20; c++) @(negedge clk);
        #2;
        chk("loop_end_pc", pc, 32'd20);
        run(5);
        chk("loop_store_count", acc_log.size(), 32'd16);
        foreach (acc_log[i]) begin
            chk("loop_addr", acc_log[i].addr, 32'd1024);
            chk("loop_data", acc_log[i].data, i);
            chk("loop_is_store", 32'(acc_log[i].ld), 32'd0);
        end

        // sign extension
        prog = '{32'hfff00093, 32'h00102023};
        restart(prog);
        run(3);
        chk("sext_count", acc_log.size(), 32'd1);
        if (acc_log.size() > 0) begin
            chk("sext_addr", acc_log[0].addr, 32'd0);
            chk("sext_data", acc_log[0].data, 32'hFFFF_FFFF);
            chk("sext_ld", 32'(acc_log[0].ld), 32'd0);
        end

        // branch not taken, then jal and link value
        prog = '{32'h00001463, NOP, 32'h010002ef, NOP, NOP, NOP, 32'h00502023};
        restart(prog);
        @(posedge clk); #1 chk("bne_nt_pc", pc, 32'd4);
        @(posedge clk); #1 chk("pre_jal_pc", pc, 32'd8);
        @(posedge clk); #1 chk("jal_pc", pc, 32'd24);
        run(2);
        chk("jal_count", acc_log.size(), 32'd1);
        if (acc_log.size() > 0) begin
            chk("jal_link", acc_log[0].data, 32'd12);
            chk("jal_store_pc", acc_log[0].pc, 32'd24);
        end

        // load writes zero
        prog = '{32'h00700113, 32'h00402103, 32'h00202023};
        restart(prog);
        run(4);
        chk("ld_count", acc_log.size(), 32'd2);
        if (acc_log.size() > 1) begin
            chk("ld_flag", 32'(acc_log[0].ld), 32'd1);
            chk("ld_addr", acc_log[0].addr, 32'd4);
            chk("ld_then_data", acc_log[1].data, 32'd0);
        end

        // x0 ignores writes
        prog = '{32'h00500013, 32'h00002023};
        restart(prog);
        run(3);
        chk("x0_count", acc_log.size(), 32'd1);
        if (acc_log.size() > 0) chk("x0_data", acc_log[0].data, 32'd0);

        // random programs, one with a reset mid-run
        for (int r = 0; r < 4; r++) begin
            prog.delete();
            for (int i = 0; i < 64; i++) prog.push_back(rand_instr());
            restart(prog);
            if (r == 2) begin
                run(100);
                @(posedge clk);
                #2 rst_n = 1'b0;
                #1;
                chk("mid_rst_pc", pc, 32'd0);
                chk("mid_rst_mem", 32'(mem), 32'd0);
                @(negedge clk);
                #1 rst_n = 1'b1;
                run(150);
            end else begin
                run(250);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
